// File: rtl/btb_predictor_if.sv
`default_nettype none
// ============================================================================
//  Module      : btb_predictor_if
//  Description : Fetch-lookup and EXE-resolution signal bundle for the BTB.
//  Revision    : 1.0  initial release
// ============================================================================
interface btb_predictor_if #(
    parameter int ADDR_W = 16
);
    logic [ADDR_W-1:0] cur_pc;
    logic              pred_taken;
    logic [ADDR_W-1:0] pred_pc;
    logic              upd_valid;
    logic [ADDR_W-1:0] upd_pc;
    logic              upd_taken;
    logic [ADDR_W-1:0] upd_target;
    logic              upd_pred_taken;
    logic [ADDR_W-1:0] upd_pred_pc;
    logic              mispredict;
    logic [ADDR_W-1:0] fix_pc;

    modport master (
        output cur_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_pc,
        input  pred_taken, pred_pc, mispredict, fix_pc
    );

    modport slave (
        input  cur_pc, upd_valid, upd_pc, upd_taken, upd_target,
               upd_pred_taken, upd_pred_pc,
        output pred_taken, pred_pc, mispredict, fix_pc
    );
endinterface
`default_nettype wire

// File: rtl/btb_predictor.sv
`default_nettype none
// ============================================================================
//  Module      : btb_predictor
//  Description : Direct-mapped BTB with tag check and 2-bit hysteresis
//                counters; combinational fetch lookup, EXE-side update and
//                mispredict report. Optional BTB_STATS_EN adds counters.
//  Revision    : 1.0  initial release
// ============================================================================
module btb_predictor #(
    parameter int         ADDR_W   = 16,
    parameter int         ENTRIES  = 8,
    parameter int         IDX_W    = $clog2(ENTRIES),
    parameter logic [1:0] CNT_INIT = 2'b10
) (
    input  wire logic         clk,
    input  wire logic         rst,
    btb_predictor_if.slave    bus
`ifdef BTB_STATS_EN
    ,
    output logic [15:0]       stat_lookups,
    output logic [15:0]       stat_branches,
    output logic [15:0]       stat_mispredicts
`endif
);

    localparam int         c_TAG_W   = ADDR_W - IDX_W;
    localparam logic [1:0] c_CNT_RST = 2'b01;
    localparam logic [1:0] c_CNT_MAX = 2'b11;
    localparam logic [1:0] c_CNT_MIN = 2'b00;

    logic                  r_valid  [ENTRIES];
    logic [c_TAG_W-1:0]    r_tag    [ENTRIES];
    logic [ADDR_W-1:0]     r_target [ENTRIES];
    logic [1:0]            r_cnt    [ENTRIES];

    // ------------------------------------------------------------------
    // Fetch-side lookup: reads pre-update contents, no write bypass
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      w_lk_idx;
    logic [c_TAG_W-1:0]    w_lk_tag;
    logic                  w_hit;
    logic                  w_pred_taken;

    assign w_lk_idx     = bus.cur_pc[IDX_W-1:0];
    assign w_lk_tag     = bus.cur_pc[ADDR_W-1:IDX_W];
    assign w_hit        = r_valid[w_lk_idx] && (r_tag[w_lk_idx] == w_lk_tag);
    assign w_pred_taken = w_hit && r_cnt[w_lk_idx][1];

    assign bus.pred_taken = w_pred_taken;
    assign bus.pred_pc    = w_pred_taken ? r_target[w_lk_idx]
                                         : bus.cur_pc + ADDR_W'(1);

    // ------------------------------------------------------------------
    // EXE-side resolution report
    // ------------------------------------------------------------------
    logic                  w_mispredict;

    assign w_mispredict = bus.upd_valid &&
                          ((bus.upd_pred_taken != bus.upd_taken) ||
                           (bus.upd_taken && (bus.upd_pred_pc != bus.upd_target)));

    assign bus.mispredict = w_mispredict;
    assign bus.fix_pc     = bus.upd_taken ? bus.upd_target
                                          : bus.upd_pc + ADDR_W'(1);

    // ------------------------------------------------------------------
    // Table update
    // ------------------------------------------------------------------
    logic [IDX_W-1:0]      w_upd_idx;
    logic [c_TAG_W-1:0]    w_upd_tag;
    logic                  w_upd_hit;

    assign w_upd_idx = bus.upd_pc[IDX_W-1:0];
    assign w_upd_tag = bus.upd_pc[ADDR_W-1:IDX_W];
    assign w_upd_hit = r_valid[w_upd_idx] && (r_tag[w_upd_idx] == w_upd_tag);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int e = 0; e < ENTRIES; e++) begin
                r_valid[e]  <= 1'b0;
                r_tag[e]    <= '0;
                r_target[e] <= '0;
                r_cnt[e]    <= c_CNT_RST;
            end
        end else if (bus.upd_valid) begin
            if (w_upd_hit) begin
                if (bus.upd_taken) begin
                    r_target[w_upd_idx] <= bus.upd_target;
                    if (r_cnt[w_upd_idx] != c_CNT_MAX) begin
                        r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] + 2'b01;
                    end
                end else if (r_cnt[w_upd_idx] != c_CNT_MIN) begin
                    r_cnt[w_upd_idx] <= r_cnt[w_upd_idx] - 2'b01;
                end
            end else if (bus.upd_taken) begin
                // Miss on a taken branch evicts whatever aliased into this slot
                r_valid[w_upd_idx]  <= 1'b1;
                r_tag[w_upd_idx]    <= w_upd_tag;
                r_target[w_upd_idx] <= bus.upd_target;
                r_cnt[w_upd_idx]    <= CNT_INIT;
            end
        end
    end

`ifdef BTB_STATS_EN
    // ------------------------------------------------------------------
    // Saturating debug counters
    // ------------------------------------------------------------------
    localparam logic [15:0] c_STAT_MAX = 16'hFFFF;

    logic [15:0] r_stat_lookups;
    logic [15:0] r_stat_branches;
    logic [15:0] r_stat_mispredicts;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_stat_lookups     <= '0;
            r_stat_branches    <= '0;
            r_stat_mispredicts <= '0;
        end else begin
            if (w_hit && (r_stat_lookups != c_STAT_MAX)) begin
                r_stat_lookups <= r_stat_lookups + 16'd1;
            end
            if (bus.upd_valid && (r_stat_branches != c_STAT_MAX)) begin
                r_stat_branches <= r_stat_branches + 16'd1;
            end
            if (w_mispredict && (r_stat_mispredicts != c_STAT_MAX)) begin
                r_stat_mispredicts <= r_stat_mispredicts + 16'd1;
            end
        end
    end

    assign stat_lookups     = r_stat_lookups;
    assign stat_branches    = r_stat_branches;
    assign stat_mispredicts = r_stat_mispredicts;
`endif

endmodule
`default_nettype wire

// File: doc/btb_predictor.md
Name: btb_predictor

Overview:
- Parametrised branch target buffer with per-entry 2-bit saturating direction counters. Successor to the single-mode BTB in the 5-stage THCO pipeline.
- Fetch side: combinational lookup of the current PC yields the predicted next PC for PC_reg.
- EXE side: branch resolution updates the table and raises a mispredict/redirect for the hazard unit.
- Generalised over address width and table depth. Adds hysteresis, tag-checked hits, and an optional statistics block.

Parameters:
ADDR_W, 16, PC/target width in bits (PC word-addressed, sequential PC = pc+1)
ENTRIES, 8, table depth; power of two, 2..64
IDX_W, $clog2(ENTRIES), index width; index = pc[IDX_W-1:0], tag = pc[ADDR_W-1:IDX_W]
CNT_INIT, 2'b10, counter value written on allocation

Ports:
clk  in  1  pipeline clock
rst  in  1  asynchronous, active-low reset
cur_pc  in  ADDR_W  fetch-stage PC
pred_taken  out  1  lookup hit and counter[1]==1
pred_pc  out  ADDR_W  predicted next PC: stored target if pred_taken, else cur_pc+1
upd_valid  in  1  EXE holds a resolved branch/jump this cycle (already gated by stall/clear)
upd_pc  in  ADDR_W  PC of resolving instruction
upd_taken  in  1  actual direction
upd_target  in  ADDR_W  actual target when taken
upd_pred_taken  in  1  prediction made for this instruction at fetch (piped through IF/ID, ID/EXE)
upd_pred_pc  in  ADDR_W  predicted next PC made at fetch
mispredict  out  1  redirect required
fix_pc  out  ADDR_W  correct next PC: upd_taken ? upd_target : upd_pc+1

Behaviour:
- Storage per entry: valid, tag (ADDR_W-IDX_W), target (ADDR_W), cnt (2 bits). Flops, not RAM.
- Reset (rst=0, async): all valid=0, cnt=2'b01, tag/target=0. pred_taken=0, pred_pc=cur_pc+1, mispredict=0 while upd_valid=0.
- Lookup is purely combinational, zero latency.
  - hit = valid[i] && tag[i]==cur_pc[ADDR_W-1:IDX_W].
  - pred_taken = hit && cnt[i][1].
- Mispredict is combinational from the upd_* inputs:
  - mispredict = upd_valid && (upd_pred_taken != upd_taken || (upd_taken && upd_pred_pc != upd_target)).
  - fix_pc is always driven; it is meaningful only when mispredict=1.
- Update happens on posedge clk when upd_valid=1, with j = upd_pc index:
  - Hit at j: cnt saturating increment if taken (max 2'b11), decrement if not (min 2'b00). If taken, target<=upd_target.
  - Miss at j and taken: allocate (overwrite any valid entry). valid<=1, tag<=upd_pc tag, target<=upd_target, cnt<=CNT_INIT.
  - Miss at j and not taken: no change.
  - upd_valid=0: table unchanged.
- Simultaneous lookup and update to the same index in one cycle: lookup returns pre-update contents (no bypass). The update is visible the following cycle.
- Wrap-around:
  - cur_pc+1 and upd_pc+1 are computed modulo 2^ADDR_W (0xFFFF+1 = 0x0000 at ADDR_W=16).
  - Target equal to own PC is legal.
- Reset asserted mid-update: the async clear wins. No partial entry survives.
- Adding the mispredict output to the hazard unit's IF/ID and ID/EXE clear and PC redirect remains the top level's job; this block only reports.

Optional Feature:
- BTB_STATS_EN defined: adds outputs stat_lookups[15:0], stat_branches[15:0], stat_mispredicts[15:0].
  - stat_lookups increments each cycle in which hit=1.
  - stat_branches increments on each upd_valid.
  - stat_mispredicts increments on each mispredict.
  - All counters saturate at 16'hFFFF and clear on reset. Added to the debug LED path.
- BTB_STATS_EN undefined: ports and counters absent. Core behaviour identical.

Test Plan:
- Reset, cur_pc=0x0040 -> pred_taken=0, pred_pc=0x0041; upd_valid=0 -> mispredict=0.
- Update upd_pc=0x0012, taken, target=0x0030, pred_taken=0, pred_pc=0x0013 -> mispredict=1, fix_pc=0x0030. Next cycle cur_pc=0x0012 -> pred_taken=1 (cnt=10), pred_pc=0x0030.
- Hysteresis on 0x0012:
  - One not-taken update -> cnt=01, lookup pred_taken=0.
  - Three taken updates -> cnt=11.
  - One not-taken -> cnt=10, still predicts 0x0030.
- Aliasing, ENTRIES=8: allocate 0x0012 taken→0x0030, then 0x001A taken→0x0050 (same index 2) -> lookup 0x0012 misses (pred_pc=0x0013), lookup 0x001A hits →0x0050.
- Same-cycle: cur_pc=0x0005 while allocating 0x0005 taken→0x0100 -> that cycle pred_pc=0x0006; next cycle pred_pc=0x0100.
- Correct prediction: upd_pc=0x0012, taken, target 0x0030, pred_taken=1, pred_pc=0x0030 -> mispredict=0. With BTB_STATS_EN, stat_branches increments and stat_mispredicts does not. Wrap check: cur_pc=0xFFFF on empty table -> pred_pc=0x0000.
